// File: rtl/e_clock_mng_gen.sv
// rtl/e_clock_mng_gen.sv - SD card clock generator: glitch-free divider, stop handshake, counted bursts
module e_clock_mng_gen #(
    parameter int               DIV_W      = 10,
    parameter int               CNT_W      = 8,
    parameter logic [DIV_W-1:0] DIV_RST    = '1,
    parameter int               STABLE_CYC = 2
) (
    input  logic             sd_clk_2x,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             sdio_on,
    input  logic [DIV_W-1:0] clock_div,
    input  logic             load_div,
    input  logic             stop_req,
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_len,
    output logic             sd_clk,
    output logic             sd_clkn,
    output logic             sd_clk_rise,
    output logic             sd_clk_fall,
    output logic             clk_stable,
    output logic             stopped,
    output logic             burst_done,
    output logic [DIV_W-1:0] cur_div
);
    localparam int              SW         = $clog2(STABLE_CYC + 2);
    localparam logic [SW-1:0]   STABLE_TGT = SW'(STABLE_CYC);

    typedef enum logic [1:0] {S_OFF, S_RUN, S_BURST, S_STOP_PEND} state_t;

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_cnt, r_cur_div, r_shadow, w_cur_div_nxt;
    logic             r_shadow_vld, w_shadow_vld_nxt;
    logic             r_sd_clk, r_sd_clkn, r_clk_stable, r_burst_done;
    logic [CNT_W-1:0] r_burst_rem;
    logic [SW-1:0]    r_stable_cnt, w_stable_nxt;
    logic             w_tick, w_clk_nxt, w_xfer, w_done_nxt, w_burst_load;

    assign w_tick = (r_cnt == '0) &&
                    ((r_state == S_RUN) || (r_state == S_BURST) ||
                     ((r_state == S_STOP_PEND) && r_sd_clk));
    // Power loss parks the clock low immediately, even mid-high-phase.
    assign w_clk_nxt        = sdio_on && (r_state != S_OFF) && (r_sd_clk ^ w_tick);
    assign w_xfer           = r_shadow_vld && ((w_tick && r_sd_clk) || (r_state == S_OFF));
    assign w_cur_div_nxt    = w_xfer ? r_shadow : r_cur_div;
    assign w_shadow_vld_nxt = load_div || (r_shadow_vld && !w_xfer);

    always_comb begin
        w_state_nxt  = r_state;
        w_done_nxt   = 1'b0;
        w_burst_load = 1'b0;
        case (r_state)
            S_OFF: begin
                if (clk_en && sdio_on && burst_start) begin
                    if (burst_len == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = S_BURST;
                        w_burst_load = 1'b1;
                    end
                end else if (clk_en && sdio_on && !stop_req) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!clk_en || stop_req) w_state_nxt = S_STOP_PEND;
            end
            S_BURST: begin
                if (!clk_en || stop_req) begin
                    w_state_nxt = S_STOP_PEND;
                end else if (w_tick && r_sd_clk && (r_burst_rem == '0)) begin
                    w_state_nxt = S_OFF;
                    w_done_nxt  = 1'b1;
                end
            end
            S_STOP_PEND: begin
                if (!r_sd_clk || w_tick) w_state_nxt = S_OFF;
            end
            default: w_state_nxt = S_OFF;
        endcase
        if (!sdio_on) begin
            w_state_nxt  = S_OFF;
            w_done_nxt   = 1'b0;
            w_burst_load = 1'b0;
        end
    end

    always_comb begin
        w_stable_nxt = r_stable_cnt;
        if (w_shadow_vld_nxt || (w_state_nxt == S_OFF)) begin
            w_stable_nxt = '0;
        end else if (w_tick && !r_sd_clk && (r_stable_cnt < STABLE_TGT)) begin
            w_stable_nxt = r_stable_cnt + SW'(1);
        end
    end

    always_ff @(posedge sd_clk_2x or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_OFF;
            r_sd_clk     <= 1'b0;
            r_sd_clkn    <= 1'b1;
            r_cnt        <= DIV_RST;
            r_cur_div    <= DIV_RST;
            r_shadow     <= DIV_RST;
            r_shadow_vld <= 1'b0;
            r_stable_cnt <= '0;
            r_clk_stable <= 1'b0;
            r_burst_rem  <= '0;
            r_burst_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sd_clk     <= w_clk_nxt;
            r_sd_clkn    <= ~w_clk_nxt;
            r_cur_div    <= w_cur_div_nxt;
            r_cnt        <= ((r_state == S_OFF) || w_tick || (w_state_nxt == S_OFF)) ?
                            w_cur_div_nxt : r_cnt - DIV_W'(1);
            if (load_div) r_shadow <= clock_div;
            r_shadow_vld <= w_shadow_vld_nxt;
            r_stable_cnt <= w_stable_nxt;
            r_clk_stable <= (w_stable_nxt >= STABLE_TGT);
            if (w_burst_load) begin
                r_burst_rem <= burst_len;
            end else if ((r_state == S_BURST) && w_tick && !r_sd_clk) begin
                r_burst_rem <= r_burst_rem - CNT_W'(1);
            end
            r_burst_done <= w_done_nxt;
        end
    end

    assign sd_clk      = r_sd_clk;
    assign sd_clkn     = r_sd_clkn;
    assign sd_clk_rise = w_clk_nxt && !r_sd_clk;
    assign sd_clk_fall = !w_clk_nxt && r_sd_clk;
    assign clk_stable  = r_clk_stable;
    assign stopped     = (r_state == S_OFF);
    assign burst_done  = r_burst_done;
    assign cur_div     = r_cur_div;
endmodule

// File: tb/tb_e_clock_mng_gen.sv
// tb/tb_e_clock_mng_gen.sv - self-checking bench for e_clock_mng_gen
module tb_e_clock_mng_gen;
    localparam int DIV_W      = 10;
    localparam int CNT_W      = 8;
    localparam int DIV_RST    = 1023;
    localparam int STABLE_CYC = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clk_en = 1'b0;
    logic             sdio_on = 1'b0;
    logic [DIV_W-1:0] clock_div = '0;
    logic             load_div = 1'b0;
    logic             stop_req = 1'b0;
    logic             burst_start = 1'b0;
    logic [CNT_W-1:0] burst_len = '0;
    logic             sd_clk, sd_clkn, sd_clk_rise, sd_clk_fall;
    logic             clk_stable, stopped, burst_done;
    logic [DIV_W-1:0] cur_div;

    e_clock_mng_gen #(
        .DIV_W(DIV_W), .CNT_W(CNT_W), .DIV_RST(10'h3FF), .STABLE_CYC(STABLE_CYC)
    ) dut (
        .sd_clk_2x(clk), .rst_n(rst_n), .clk_en(clk_en), .sdio_on(sdio_on),
        .clock_div(clock_div), .load_div(load_div), .stop_req(stop_req),
        .burst_start(burst_start), .burst_len(burst_len),
        .sd_clk(sd_clk), .sd_clkn(sd_clkn), .sd_clk_rise(sd_clk_rise),
        .sd_clk_fall(sd_clk_fall), .clk_stable(clk_stable), .stopped(stopped),
        .burst_done(burst_done), .cur_div(cur_div)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int rise_total = 0;
    int done_total = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Behavioural reference: phase age counts up; a phase lasts div+1 cycles.
    bit m_off = 1, m_burst = 0, m_stopping = 0, m_clk = 0, m_done = 0, m_shv = 0;
    int m_age = 0, m_div = DIV_RST, m_sh = DIV_RST, m_rc = 0, m_left = 0;

    always @(negedge clk) begin
        bit tk, nclk, rise_tk, fall_tk, xfer, was_off;
        if (sd_clk_rise === 1'b1) rise_total++;
        if (burst_done === 1'b1) done_total++;
        if (!rst_n) begin
            chk("rst_sd_clk", sd_clk, 0);
            chk("rst_sd_clkn", sd_clkn, 1);
            chk("rst_stopped", stopped, 1);
            chk("rst_clk_stable", clk_stable, 0);
            chk("rst_burst_done", burst_done, 0);
            chk("rst_cur_div", cur_div, DIV_RST);
            m_off = 1; m_burst = 0; m_stopping = 0; m_clk = 0; m_done = 0; m_shv = 0;
            m_age = 0; m_div = DIV_RST; m_rc = 0; m_left = 0;
        end else begin
            tk      = !m_off && (m_age == m_div) && (!m_stopping || m_clk);
            nclk    = sdio_on && !m_off && (m_clk ^ tk);
            chk("sd_clk", sd_clk, m_clk);
            chk("sd_clkn", sd_clkn, !m_clk);
            chk("stopped", stopped, m_off);
            chk("burst_done", burst_done, m_done);
            chk("clk_stable", clk_stable, m_rc >= STABLE_CYC);
            chk("cur_div", cur_div, m_div);
            chk("sd_clk_rise", sd_clk_rise, nclk && !m_clk);
            chk("sd_clk_fall", sd_clk_fall, !nclk && m_clk);
            rise_tk = tk && !m_clk;
            fall_tk = tk && m_clk;
            xfer    = m_shv && (fall_tk || m_off);
            was_off = m_off;
            m_done  = 0;
            if (m_burst && rise_tk) m_left--;
            if (!sdio_on) begin
                m_off = 1; m_burst = 0; m_stopping = 0;
            end else if (m_off) begin
                if (clk_en && burst_start) begin
                    if (burst_len == 0) m_done = 1;
                    else begin m_off = 0; m_burst = 1; m_left = burst_len; end
                end else if (clk_en && !stop_req) begin
                    m_off = 0;
                end
            end else if (m_stopping) begin
                if (!m_clk || fall_tk) begin m_off = 1; m_stopping = 0; end
            end else if (!clk_en || stop_req) begin
                m_stopping = 1; m_burst = 0;
            end else if (m_burst && fall_tk && m_left == 0) begin
                m_off = 1; m_burst = 0; m_done = 1;
            end
            if (xfer) m_div = m_sh;
            m_shv = load_div || (m_shv && !xfer);
            if (load_div) m_sh = clock_div;
            m_age = (was_off || m_off || tk) ? 0 : m_age + 1;
            if (m_shv || m_off) m_rc = 0;
            else if (rise_tk) m_rc++;
            m_clk = nclk;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic until_clk(input logic val, output int k);
        k = 0;
        do begin step(); k++; end while (sd_clk !== val && k < 5000);
        chk("until_clk_bound", sd_clk === val, 1);
    endtask

    task automatic go_off();
        int k = 0;
        clk_en = 1'b0;
        while (stopped !== 1'b1 && k < 5000) begin step(); k++; end
        chk("go_off_bound", stopped, 1);
    endtask

    task automatic load_off(input int d);
        load_div = 1'b1; clock_div = DIV_W'(d);
        step();
        load_div = 1'b0;
        step();
        chk("load_off_cur_div", cur_div, d);
    endtask

    initial begin
        int k, hi, lo, rsnap, dsnap;
        step(); step();
        chk("reset_sd_clk", sd_clk, 0);
        chk("reset_stopped", stopped, 1);
        // default divider after reset
        rst_n = 1'b1; clk_en = 1'b1; sdio_on = 1'b1;
        step();
        chk("enable_stopped_fall", stopped, 0);
        until_clk(1, k); chk("default_first_low", k, 1024);
        until_clk(0, hi); until_clk(1, lo);
        chk("default_high", hi, 1024);
        chk("default_period", hi + lo, 2048);
        // divider 0 and 3 loaded while off
        go_off(); load_off(0); clk_en = 1'b1;
        until_clk(1, k); chk("div0_stable_after_1rise", clk_stable, 0);
        until_clk(0, hi); until_clk(1, lo);
        chk("div0_period", hi + lo, 2);
        chk("div0_stable_after_2rise", clk_stable, 1);
        go_off(); load_off(3); clk_en = 1'b1;
        until_clk(1, k); chk("div3_stable_after_1rise", clk_stable, 0);
        until_clk(0, hi); until_clk(1, lo);
        chk("div3_high", hi, 4);
        chk("div3_period", hi + lo, 8);
        chk("div3_stable_after_2rise", clk_stable, 1);
        // glitch-free reload to 0 in the middle of a high phase
        until_clk(0, k); until_clk(1, k);
        step();
        load_div = 1'b1; clock_div = '0;
        step();
        load_div = 1'b0;
        chk("reload_stable_cleared", clk_stable, 0);
        until_clk(0, k); chk("reload_high_rest", k, 2);
        until_clk(1, lo); chk("reload_new_low", lo, 1);
        chk("reload_stable_1rise", clk_stable, 0);
        until_clk(0, hi); chk("reload_new_high", hi, 1);
        until_clk(1, k); chk("reload_stable_2rise", clk_stable, 1);
        // stop handshake at divider 3
        load_div = 1'b1; clock_div = 10'd3;
        step();
        load_div = 1'b0;
        until_clk(1, k); until_clk(0, k); until_clk(1, k);
        stop_req = 1'b1;
        until_clk(0, k); chk("stop_high_len", k, 4);
        chk("stop_stopped_after_fall", stopped, 1);
        stop_req = 1'b0;
        until_clk(1, k); chk("stop_restart_delay", k, 5);
        // counted bursts
        go_off(); load_off(1);
        rsnap = rise_total; dsnap = done_total;
        clk_en = 1'b1; burst_start = 1'b1; burst_len = 8'd80;
        step();
        burst_start = 1'b0;
        k = 0;
        while (burst_done !== 1'b1 && k < 2000) begin step(); k++; end
        chk("burst80_done_seen", burst_done, 1);
        chk("burst80_rises", rise_total - rsnap, 80);
        chk("burst80_stopped", stopped, 1);
        chk("burst80_sd_clk", sd_clk, 0);
        clk_en = 1'b0;
        step(); step(); step();
        chk("burst80_done_pulses", done_total - dsnap, 1);
        rsnap = rise_total;
        stop_req = 1'b1; clk_en = 1'b1; burst_start = 1'b1; burst_len = '0;
        step();
        burst_start = 1'b0;
        chk("burst0_done", burst_done, 1);
        chk("burst0_stopped", stopped, 1);
        step();
        chk("burst0_done_single", burst_done, 0);
        chk("burst0_no_edges", rise_total - rsnap, 0);
        // power drop mid-burst
        stop_req = 1'b0; dsnap = done_total;
        burst_start = 1'b1; burst_len = 8'd50;
        step();
        burst_start = 1'b0;
        repeat (9) step();
        sdio_on = 1'b0;
        step();
        chk("pwr_drop_sd_clk", sd_clk, 0);
        chk("pwr_drop_stopped", stopped, 1);
        repeat (5) step();
        chk("pwr_drop_no_done", done_total - dsnap, 0);
        // asynchronous reset in the middle of a high phase
        sdio_on = 1'b1;
        until_clk(1, k);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_sd_clk", sd_clk, 0);
        chk("async_rst_sd_clkn", sd_clkn, 1);
        chk("async_rst_cur_div", cur_div, DIV_RST);
        step(); step();
        rst_n = 1'b1;
        step();
        chk("post_rst_stopped", stopped, 0);
        until_clk(1, k); chk("post_rst_first_low", k, 1024);
        // randomized traffic against the model
        go_off(); load_off(2);
        clk_en = 1'b1; stop_req = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            sdio_on     = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 29) == 0) clk_en = ~clk_en;
            if ($urandom_range(0, 39) == 0) stop_req = ~stop_req;
            load_div    = ($urandom_range(0, 24) == 0);
            clock_div   = DIV_W'($urandom_range(0, 4));
            burst_start = ($urandom_range(0, 9) == 0);
            burst_len   = CNT_W'($urandom_range(0, 6));
            step();
        end
        load_div = 1'b0; burst_start = 1'b0;
        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
